trotrig_capture: RTL and testbench



---
 rtl/trotrig_capture.sv | 144 ++++++++++++++
 tb/tb_trotrig_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/trotrig_capture.sv
// rtl/trotrig_capture.sv - circular pre/post-trigger sample capture with valid/ready readout
// Optional feature macro: TROTRIG_CAPTURE_REARM_EN (auto re-arm after each readout).
module trotrig_capture #(
  parameter int DINBITS   = 8,
  parameter int DEPTHBITS = 4,
  parameter int PRETRIG   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [DINBITS-1:0] din,
  input  logic               trigger,
  output logic               armed,
  output logic               triggered,
  output logic               done,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [DINBITS-1:0] rd_data,
  output logic               rd_last
);

  localparam int DEPTH = 2 ** DEPTHBITS;
  localparam int POSTN = DEPTH - PRETRIG - 1;
  localparam logic [DEPTHBITS-1:0] PRE_W  = DEPTHBITS'(PRETRIG);
  localparam logic [DEPTHBITS-1:0] POST_W = DEPTHBITS'(POSTN);
  localparam logic [DEPTHBITS:0]   DEPTH_W = (DEPTHBITS + 1)'(DEPTH);

  typedef enum logic [2:0] {S_FILL, S_ARMED, S_POST, S_READOUT, S_DONE} state_t;

  state_t state_q, state_d;
  logic [DINBITS-1:0]   mem [DEPTH];
  logic [DEPTHBITS-1:0] wptr_q;
  logic [DEPTHBITS-1:0] fill_cnt_q, fill_cnt_d;
  logic [DEPTHBITS-1:0] post_cnt_q, post_cnt_d;
  logic [DEPTHBITS-1:0] raddr_q, raddr_d;
  logic [DEPTHBITS:0]   issued_q, issued_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_last_q, rd_last_d;
  logic [DINBITS-1:0]   rd_data_q;
  logic                 writing, hit, xfer, load;

  assign writing = enable && (state_q inside {S_FILL, S_ARMED, S_POST});
  assign hit     = enable && trigger && (state_q == S_ARMED);
  assign xfer    = rd_valid_q && rd_ready;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign load    = (state_q == S_READOUT) && (!rd_valid_q || rd_ready) && (issued_q != DEPTH_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FILL;
      wptr_q     <= '0;
      fill_cnt_q <= '0;
      post_cnt_q <= '0;
      raddr_q    <= '0;
      issued_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= writing ? wptr_q + 1'b1 : wptr_q;
      fill_cnt_q <= fill_cnt_d;
      post_cnt_q <= post_cnt_d;
      raddr_q    <= raddr_d;
      issued_q   <= issued_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      if (load) rd_data_q <= mem[raddr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (writing) mem[wptr_q] <= din;
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    post_cnt_d = post_cnt_q;
    raddr_d    = raddr_q;
    issued_d   = issued_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    case (state_q)
      S_FILL: begin
        if (PRETRIG == 0) begin
          state_d = S_ARMED;
        end else if (enable) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == PRE_W - 1'b1) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (hit) begin
          post_cnt_d = '0;
          issued_d   = '0;
          // Window start: PRETRIG entries behind the trigger address, modulo depth.
          raddr_d    = wptr_q - PRE_W;
          state_d    = (POSTN == 0) ? S_READOUT : S_POST;
        end
      end
      S_POST: begin
        if (enable) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_q == POST_W - 1'b1) state_d = S_READOUT;
        end
      end
      S_READOUT: begin
        if (xfer && rd_last_q) state_d = S_DONE;
      end
      S_DONE: begin
`ifdef TROTRIG_CAPTURE_REARM_EN
        state_d    = S_FILL;
        fill_cnt_d = '0;
        post_cnt_d = '0;
`else
        state_d    = S_DONE;
`endif
      end
      default: state_d = S_FILL;
    endcase

    if (load) begin
      raddr_d    = raddr_q + 1'b1;
      issued_d   = issued_q + 1'b1;
      rd_valid_d = 1'b1;
      rd_last_d  = (issued_q == DEPTH_W - 1'b1);
    end else if (xfer) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end
  end

  always_comb begin
    armed     = (state_q == S_ARMED);
    triggered = (state_q == S_POST) || (state_q == S_READOUT);
    done      = (state_q == S_DONE);
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_trotrig_capture.sv
// tb/tb_trotrig_capture.sv - randomized scoreboard bench for trotrig_capture
module tb_trotrig_capture;

  localparam int DINBITS   = 8;
  localparam int DEPTHBITS = 4;
  localparam int PRETRIG   = 4;
  localparam int DEPTH     = 2 ** DEPTHBITS;
  localparam int POSTN     = DEPTH - PRETRIG - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic [DINBITS-1:0] din = '0;
  logic               trigger = 1'b0;
  logic               armed, triggered, done, rd_valid, rd_last;
  logic               rd_ready = 1'b1;
  logic [DINBITS-1:0] rd_data;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int ready_pct = 100;
  logic [DINBITS:0] exp_q[$];

  trotrig_capture #(.DINBITS(DINBITS), .DEPTHBITS(DEPTHBITS), .PRETRIG(PRETRIG)) dut (
    .clk(clk), .reset(reset), .enable(enable), .din(din), .trigger(trigger),
    .armed(armed), .triggered(triggered), .done(done), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    rd_ready = ($urandom_range(0, 99) < ready_pct);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected words on every transfer, and checks hold-under-stall.
  logic [DINBITS:0]   mon_e;
  logic               mon_stall = 1'b0;
  logic [DINBITS-1:0] mon_held = '0;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      mon_stall = 1'b0;
    end else begin
      if (mon_stall) begin
        check("stall_valid", int'(rd_valid), 1);
        check("stall_data", int'(rd_data), int'(mon_held));
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got=%0d want=none", rd_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_data", int'(rd_data), int'(mon_e[DINBITS-1:0]));
          check("rd_last", int'(rd_last), int'(mon_e[DINBITS]));
        end
        rx_cnt++;
      end
      mon_stall = rd_valid && !rd_ready;
      mon_held  = rd_data;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    trigger = 1'b0;
    step();
    reset = 1'b0;
    exp_q.delete();
    check("reset_flags", int'({armed, triggered, done, rd_valid, rd_last}), 0);
    check("reset_data", int'(rd_data), 0);
  endtask

  // Reference: the window is the enabled-sample list sliced around the first
  // trigger seen once PRETRIG samples exist, ending POSTN samples later.
  task automatic capture(input int start, input int trig_val, input bit gaps, input int pulse_at);
    int d, tidx, cyc, v;
    int s[$];
    d = start;
    tidx = -1;
    cyc = 0;
    while (!(tidx >= 0 && s.size() == tidx + POSTN + 1) && cyc < 1000) begin
      if (gaps && cyc[0]) begin
        enable = 1'b0;
        din = DINBITS'($urandom);
        trigger = (d < trig_val);
      end else begin
        enable = 1'b1;
        din = DINBITS'(d);
        trigger = (d >= trig_val) || (d == pulse_at);
        if (tidx < 0 && trigger && s.size() >= PRETRIG) tidx = s.size();
        s.push_back(d);
        d++;
      end
      cyc++;
      step();
      check("armed", int'(armed), int'(s.size() >= PRETRIG && tidx < 0));
      check("triggered", int'(triggered), int'(tidx >= 0));
    end
    enable = 1'b0;
    trigger = 1'b0;
    if (tidx < 0) begin
      check("capture_trigger_found", 0, 1);
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        v = s[tidx - PRETRIG + k];
        exp_q.push_back({k == DEPTH - 1, v[DINBITS-1:0]});
      end
    end
  endtask

  task automatic wait_rx(input int n, input string name);
    int base, k;
    base = rx_cnt;
    k = 0;
    while (rx_cnt - base < n && k < 2000) begin
      step();
      k++;
    end
    check(name, rx_cnt - base, n);
  endtask

  initial begin
    int base;
    // basic capture at full rate
    do_reset();
    capture(0, 10, 1'b0, -1);
    wait_rx(DEPTH, "basic_words");
    check("basic_done", int'(done), 1);
    check("basic_valid_low", int'(rd_valid), 0);

    // trigger pulse during FILL is ignored
    do_reset();
    capture(0, 7, 1'b0, 2);
    wait_rx(DEPTH, "fill_words");
    check("fill_done", int'(done), 1);

    // enable gaps with trigger on disabled cycles
    do_reset();
    capture(0, 10, 1'b1, -1);
    wait_rx(DEPTH, "gap_words");
    check("gap_done", int'(done), 1);

    // random backpressure
    do_reset();
    ready_pct = 30;
    capture(0, 10, 1'b0, -1);
    wait_rx(DEPTH, "bp_words");
    check("bp_done", int'(done), 1);
    ready_pct = 100;

    // reset mid-readout, then fresh capture
    do_reset();
    capture(0, 10, 1'b0, -1);
    wait_rx(5, "mid_words");
    do_reset();
    capture(22, 30, 1'b0, -1);
    wait_rx(DEPTH, "after_reset_words");
    check("after_reset_done", int'(done), 1);

    // second trigger after a completed readout
    do_reset();
    capture(0, 10, 1'b0, -1);
    wait_rx(DEPTH, "rearm_first_words");
    check("rearm_first_done", int'(done), 1);
`ifdef TROTRIG_CAPTURE_REARM_EN
    step();
    check("rearm_done_pulse", int'(done), 0);
    capture(32, 40, 1'b0, -1);
    wait_rx(DEPTH, "rearm_second_words");
    check("rearm_second_done", int'(done), 1);
`else
    base = rx_cnt;
    for (int i = 0; i < 40; i++) begin
      enable = 1'b1;
      din = DINBITS'(32 + i);
      trigger = (32 + i >= 40);
      step();
    end
    enable = 1'b0;
    trigger = 1'b0;
    step();
    check("terminal_done", int'(done), 1);
    check("terminal_no_words", rx_cnt - base, 0);
    check("terminal_flags", int'({armed, triggered, rd_valid}), 0);
`endif
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
